// File: rtl/wptr_ctrl.sv
// Write-side pointer controller for the async FIFO: pointers, level, full/afull.
// Define WPTR_CTRL_OVF_EN to build the sticky overflow flag.
module wptr_ctrl #(
   parameter int PTR_SIZE     = 8,
   parameter int AFULL_MARGIN = 4
) (
   input  logic              w_clk,
   input  logic              wrst,
   input  logic              w_en,
   input  logic [PTR_SIZE:0] g_rptr_sync,
   output logic              w_accept,
   output logic [PTR_SIZE:0] b_wptr,
   output logic [PTR_SIZE:0] g_wptr,
   output logic              full,
   output logic              almost_full,
   output logic [PTR_SIZE:0] wlevel,
   output logic              wovf
);

   localparam int DEPTH = 2 ** PTR_SIZE;
   localparam logic [PTR_SIZE:0] DEPTH_V = (PTR_SIZE + 1)'(DEPTH);
   localparam logic [PTR_SIZE:0] AF_TH =
      (PTR_SIZE + 1)'(DEPTH - AFULL_MARGIN);

   function automatic logic [PTR_SIZE:0] gray2bin(
      input logic [PTR_SIZE:0] g
   );
      logic [PTR_SIZE:0] b;
      b[PTR_SIZE] = g[PTR_SIZE];
      for (int i = PTR_SIZE - 1; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   logic [PTR_SIZE:0] b_rptr;
   logic [PTR_SIZE:0] b_next;
   logic [PTR_SIZE:0] g_next;
   logic [PTR_SIZE:0] lvl_next;

   assign w_accept = w_en & ~full;
   assign b_rptr   = gray2bin(g_rptr_sync);
   assign b_next   = b_wptr + {{PTR_SIZE{1'b0}}, w_accept};
   assign g_next   = b_next ^ (b_next >> 1);
   // Modular difference stays within 0..DEPTH across pointer wrap.
   assign lvl_next = b_next - b_rptr;

   always_ff @(posedge w_clk) begin
      if (wrst) begin
         b_wptr      <= '0;
         g_wptr      <= '0;
         wlevel      <= '0;
         full        <= 1'b0;
         almost_full <= 1'b0;
      end else begin
         b_wptr      <= b_next;
         g_wptr      <= g_next;
         wlevel      <= lvl_next;
         full        <= (lvl_next == DEPTH_V);
         almost_full <= (lvl_next >= AF_TH);
      end
   end

`ifdef WPTR_CTRL_OVF_EN
   always_ff @(posedge w_clk) begin
      if (wrst) begin
         wovf <= 1'b0;
      end else begin
         wovf <= wovf | (w_en & full);
      end
   end
`else
   assign wovf = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_ctrl.sv
// Randomised bench for wptr_ctrl against a write/read count model.
// Directed scenarios pin the model with literal expectations.
module tb_wptr_ctrl;

   localparam int PS = 4;
   localparam int DEPTH = 16;
   localparam int AFM = 4;
`ifdef WPTR_CTRL_OVF_EN
   localparam int OVF_ON = 1;
`else
   localparam int OVF_ON = 0;
`endif

   logic          w_clk = 1'b0;
   logic          wrst = 1'b1;
   logic          w_en = 1'b0;
   logic [PS:0]   g_rptr_sync = '0;
   logic          w_accept;
   logic [PS:0]   b_wptr;
   logic [PS:0]   g_wptr;
   logic          full;
   logic          almost_full;
   logic [PS:0]   wlevel;
   logic          wovf;

   wptr_ctrl #(.PTR_SIZE(PS), .AFULL_MARGIN(AFM)) dut (
      .w_clk(w_clk), .wrst(wrst), .w_en(w_en),
      .g_rptr_sync(g_rptr_sync), .w_accept(w_accept),
      .b_wptr(b_wptr), .g_wptr(g_wptr), .full(full),
      .almost_full(almost_full), .wlevel(wlevel), .wovf(wovf)
   );

   always #5 w_clk = ~w_clk;

   int passed = 0;
   int total = 0;

   // model: total accepted writes, read count, registered view
   int  mw = 0;
   int  rcnt = 0;
   int  mlvl = 0;
   bit  mfull = 0;
   bit  maf = 0;
   bit  movf = 0;
   bit  mvalid = 0;

   function automatic logic [PS:0] gray(input int v);
      logic [PS:0] b;
      b = v[PS:0];
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
   endtask

   task automatic set_r(input int r);
      rcnt = r;
      g_rptr_sync = gray(r);
   endtask

   task automatic step();
      bit acc;
      @(posedge w_clk);
      if (wrst) begin
         mw = 0; mlvl = 0; mfull = 0; maf = 0; movf = 0;
         mvalid = 1;
      end else begin
         acc = w_en && !mfull;
         if (w_en && mfull) movf = 1;
         mw += int'(acc);
         mlvl = mw - rcnt;
         mfull = (mlvl == DEPTH);
         maf = (mlvl >= DEPTH - AFM);
      end
      #2;
   endtask

   always @(negedge w_clk) begin
      if (mvalid) begin
         chk("w_accept", int'(w_accept), int'(w_en && !mfull));
         chk("b_wptr", int'(b_wptr), mw % 32);
         chk("g_wptr", int'(g_wptr), int'(gray(mw)));
         chk("wlevel", int'(wlevel), mlvl);
         chk("full", int'(full), int'(mfull));
         chk("almost_full", int'(almost_full), int'(maf));
         chk("wovf", int'(wovf), OVF_ON ? int'(movf) : 0);
      end
   end

   initial begin
      bit saw_b;
      bit saw_g;
      int pb;
      int pg;
      // reset with writes requested
      wrst = 1; w_en = 1; set_r(0);
      step();
      step();
      wrst = 0; w_en = 0;
      #1;
      chk("rst_accept", int'(w_accept), 0);
      chk("rst_b", int'(b_wptr), 0);
      chk("rst_lvl", int'(wlevel), 0);
      chk("rst_full", int'(full), 0);
      // fill
      w_en = 1;
      for (int i = 1; i <= 16; i++) begin
         step();
         if (i == 12) begin
            chk("fill12_lvl", int'(wlevel), 12);
            chk("fill12_af", int'(almost_full), 1);
            chk("model12", mlvl, 12);
         end
      end
      chk("fill_full", int'(full), 1);
      chk("fill_b", int'(b_wptr), 16);
      chk("fill_g", int'(g_wptr), 24);
      // write while full
      #1;
      chk("full_accept", int'(w_accept), 0);
      step();
      chk("ovf_b", int'(b_wptr), 16);
      chk("ovf_g", int'(g_wptr), 24);
      chk("ovf_flag", int'(wovf), OVF_ON);
      // release
      w_en = 0; set_r(3);
      chk("gr3", int'(g_rptr_sync), 2);
      step();
      chk("rel_full", int'(full), 0);
      chk("rel_lvl", int'(wlevel), 13);
      chk("rel_af", int'(almost_full), 1);
      chk("rel_ovf", int'(wovf), OVF_ON);
      // wrap with read trailing by 2
      set_r(14);
      step();
      chk("pre_wrap_lvl", int'(wlevel), 2);
      saw_b = 0; saw_g = 0;
      w_en = 1;
      for (int i = 0; i < 40; i++) begin
         pb = int'(b_wptr);
         pg = int'(g_wptr);
         set_r(mw - 1);
         step();
         if (pb == 31 && b_wptr == 0) saw_b = 1;
         if (pg == 16 && g_wptr == 0) saw_g = 1;
         if (wlevel != 2 || full) begin
            chk("wrap_lvl", int'(wlevel), 2);
            chk("wrap_full", int'(full), 0);
         end
      end
      chk("wrap_b_roll", int'(saw_b), 1);
      chk("wrap_g_roll", int'(saw_g), 1);
      chk("wrap_b_end", int'(b_wptr), 56 % 32);
      // random writes and read advances
      for (int i = 0; i < 400; i++) begin
         w_en = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 2) == 0)
            set_r(rcnt + int'($urandom_range(0, mw - rcnt)));
         step();
      end
      // fill up, overflow, then reset mid-operation
      w_en = 1;
      for (int i = 0; i < 40 && !mfull; i++) step();
      chk("refill_full", int'(full), 1);
      step();
      chk("refill_ovf", int'(wovf), OVF_ON);
      wrst = 1; w_en = 0; set_r(0);
      step();
      chk("mid_rst_b", int'(b_wptr), 0);
      chk("mid_rst_full", int'(full), 0);
      chk("mid_rst_ovf", int'(wovf), 0);
      chk("mid_rst_lvl", int'(wlevel), 0);
      wrst = 0; w_en = 1;
      step();
      chk("post_rst_b", int'(b_wptr), 1);
      w_en = 0;
      step();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
